// File: rtl/fft_pkg.sv
// Shared constants, FSM state encodings and helper functions for the FFT
// input frame buffer.
package fft_pkg;

    localparam int MAX_LOG2N = 12;
    localparam int MAX_DW    = 32;

    localparam logic [0:0] WR_IDLE   = 1'b0;
    localparam logic [0:0] WR_FILL   = 1'b1;
    localparam logic [0:0] RD_IDLE   = 1'b0;
    localparam logic [0:0] RD_STREAM = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Reverse the low 'width' bits of value; the upper bits of value must be 0.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                    input int width);
        logic [MAX_LOG2N-1:0] r;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            r[i] = value[MAX_LOG2N-1-i];
        end
        return r >> (MAX_LOG2N - width);
    endfunction

    // Two's complement negate of a sign-extended 'width'-bit value; the most
    // negative code maps to the most positive one instead of wrapping.
    function automatic logic [MAX_DW-1:0] sat_neg(input logic [MAX_DW-1:0] value,
                                                  input int width);
        logic [MAX_DW-1:0] min_v;
        min_v = {MAX_DW{1'b1}} << (width - 1);
        if (value == min_v) return ~min_v;
        return -value;
    endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// One frame bank: single synchronous write port, asynchronous read port.
module fft_bank_ram
    import fft_pkg::*;
#(
    parameter  int DEPTH = 256,
    parameter  int WIDTH = 32,
    localparam int AW    = clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is deliberately not reset; bank validity lives in the
    // parent's full flags, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_frame_buf.sv
// Ping-pong input frame buffer for the FFT core: fills one bank in natural
// order while the other streams out (optionally bit-reversed and conjugated).
module fft_frame_buf
    import fft_pkg::*;
#(
    parameter int LOG2N    = 8,
    parameter int DW       = 16,
    parameter int BITREV   = 1,
    parameter int CONJ_INV = 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          inv_in,
    input  logic          valid_in,
    input  logic          sop_in,
    output logic          in_ready,
    input  logic [DW-1:0] x_re,
    input  logic [DW-1:0] x_im,
    output logic          valid_out,
    input  logic          out_ready,
    output logic          sop_out,
    output logic          eop_out,
    output logic          inv_out,
    output logic [DW-1:0] y_re,
    output logic [DW-1:0] y_im,
    output logic          err_sop
);

    localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};

    logic             wr_state;
    logic             wr_bank;
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] wr_addr;
    logic             accept;
    logic             wr_en;
    logic             wr_last;
    logic [2*DW-1:0]  wr_data;

    logic             rd_state;
    logic             rd_bank;
    logic [LOG2N-1:0] rd_cnt;
    logic [LOG2N-1:0] rd_addr;
    logic             rd_go;
    logic             rd_load;
    logic             rd_last;
    logic [2*DW-1:0]  rd_data0;
    logic [2*DW-1:0]  rd_data1;
    logic [2*DW-1:0]  rd_data;

    logic [1:0]       full;
    logic [1:0]       full_set;
    logic [1:0]       full_clr;
    logic [1:0]       bank_inv;

    logic [MAX_DW-1:0] im_ext;
    logic [DW-1:0]     im_neg;
    logic [DW-1:0]     y_im_next;

    // ---------------- write side ----------------
    assign in_ready = ~full[wr_bank];
    assign accept   = valid_in & in_ready;
    assign wr_en    = accept & (sop_in | (wr_state == WR_FILL));
    assign wr_addr  = sop_in ? '0 : wr_cnt;
    assign wr_last  = wr_en & (wr_addr == LAST);
    assign wr_data  = {x_re, x_im};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            wr_bank  <= 1'b0;
            wr_cnt   <= '0;
            bank_inv <= 2'b00;
            err_sop  <= 1'b0;
        end else begin
            err_sop <= accept & sop_in & (wr_state == WR_FILL) & (wr_cnt != '0);
            if (wr_en) begin
                if (sop_in) bank_inv[wr_bank] <= inv_in;
                if (wr_last) begin
                    wr_state <= WR_IDLE;
                    wr_bank  <= ~wr_bank;
                    wr_cnt   <= '0;
                end else begin
                    wr_state <= WR_FILL;
                    wr_cnt   <= wr_addr + 1'b1;
                end
            end
        end
    end

    fft_bank_ram #(.DEPTH(1 << LOG2N), .WIDTH(2*DW)) u_bank0 (
        .clk   (clk),
        .we    (wr_en & ~wr_bank),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data0)
    );

    fft_bank_ram #(.DEPTH(1 << LOG2N), .WIDTH(2*DW)) u_bank1 (
        .clk   (clk),
        .we    (wr_en & wr_bank),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data1)
    );

    // Set and clear never target the same bank: the writer only completes a
    // non-full bank, the reader only releases a full one.
    assign full_set = wr_last ? (2'b01 << wr_bank) : 2'b00;
    assign full_clr = rd_last ? (2'b01 << rd_bank) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) full <= 2'b00;
        else     full <= (full | full_set) & ~full_clr;
    end

    // ---------------- read side ----------------
    assign rd_addr = (BITREV != 0) ? LOG2N'(bitrev(MAX_LOG2N'(rd_cnt), LOG2N)) : rd_cnt;
    assign rd_data = rd_bank ? rd_data1 : rd_data0;

    // Starting on full[] directly (not after an IDLE->STREAM hop) gives the
    // one-edge fill-to-output latency.
    assign rd_go   = (rd_state == RD_STREAM) | full[rd_bank];
    assign rd_load = rd_go & (~valid_out | out_ready);
    assign rd_last = rd_load & (rd_cnt == LAST);

    assign im_ext    = MAX_DW'(signed'(rd_data[DW-1:0]));
    assign im_neg    = DW'(sat_neg(im_ext, DW));
    assign y_im_next = ((CONJ_INV != 0) && bank_inv[rd_bank]) ? im_neg : rd_data[DW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state  <= RD_IDLE;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            inv_out   <= 1'b0;
            y_re      <= '0;
            y_im      <= '0;
        end else if (rd_load) begin
            valid_out <= 1'b1;
            y_re      <= rd_data[2*DW-1:DW];
            y_im      <= y_im_next;
            sop_out   <= (rd_cnt == '0);
            eop_out   <= (rd_cnt == LAST);
            inv_out   <= bank_inv[rd_bank];
            if (rd_last) begin
                rd_cnt   <= '0;
                rd_bank  <= ~rd_bank;
                rd_state <= full[~rd_bank] ? RD_STREAM : RD_IDLE;
            end else begin
                rd_cnt   <= rd_cnt + 1'b1;
                rd_state <= RD_STREAM;
            end
        end else if (out_ready) begin
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_frame_buf.sv
// Directed bench for fft_frame_buf with N = 8: bit-reversed order, back-to-back
// frames, backpressure, early sop, conjugation and reset mid-stream.
module tb_fft_frame_buf;

    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int DW    = 16;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          inv_in    = 1'b0;
    logic          valid_in  = 1'b0;
    logic          sop_in    = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] x_re      = '0;
    logic [DW-1:0] x_im      = '0;
    logic          in_ready;
    logic          valid_out;
    logic          sop_out;
    logic          eop_out;
    logic          inv_out;
    logic [DW-1:0] y_re;
    logic [DW-1:0] y_im;
    logic          err_sop;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sop;
        logic          eop;
        logic          inv;
        int            cyc;
    } beat_t;

    beat_t q[$];
    int    checks     = 0;
    int    errors     = 0;
    int    cycle      = 0;
    int    err_pulses = 0;

    fft_frame_buf #(.LOG2N(LOG2N), .DW(DW), .BITREV(1), .CONJ_INV(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .inv_in    (inv_in),
        .valid_in  (valid_in),
        .sop_in    (sop_in),
        .in_ready  (in_ready),
        .x_re      (x_re),
        .x_im      (x_im),
        .valid_out (valid_out),
        .out_ready (out_ready),
        .sop_out   (sop_out),
        .eop_out   (eop_out),
        .inv_out   (inv_out),
        .y_re      (y_re),
        .y_im      (y_im),
        .err_sop   (err_sop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Record every accepted output beat and every err_sop pulse.
    always @(negedge clk) begin
        if (!rst && valid_out && out_ready)
            q.push_back('{y_re, y_im, sop_out, eop_out, inv_out, cycle});
        if (!rst && err_sop) err_pulses++;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int br3(input int v);
        return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
    endfunction

    task automatic beat(input logic s, input logic iv, input logic [DW-1:0] re,
                        input logic [DW-1:0] im, output logic acc);
        valid_in = 1'b1;
        sop_in   = s;
        inv_in   = iv;
        x_re     = re;
        x_im     = im;
        acc      = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic stop_in();
        valid_in = 1'b0;
        sop_in   = 1'b0;
        inv_in   = 1'b0;
    endtask

    task automatic send_frame(input logic iv, input int base_re, input int base_im,
                              inout int refused);
        logic acc;
        for (int i = 0; i < N; i++) begin
            beat(i == 0, iv && (i == 0), DW'(base_re + i), DW'(base_im + i), acc);
            if (!acc) refused++;
        end
    endtask

    task automatic wait_q(input string tag, input int n, input int budget);
        for (int c = 0; c < budget && q.size() < n; c++) @(posedge clk);
        #1;
        check(tag, q.size(), n);
    endtask

    logic [DW-1:0] im_in   [N] = '{16'h8000, 16'h03E8, 16'h0000, 16'h0003,
                                   16'h0004, 16'h0005, 16'h0006, 16'h0007};
    logic [DW-1:0] im_conj [N] = '{16'h7FFF, 16'hFC18, 16'h0000, 16'hFFFD,
                                   16'hFFFC, 16'hFFFB, 16'hFFFA, 16'hFFF9};

    initial begin
        int   refused;
        int   gaps;
        int   sops;
        int   idx;
        logic acc;
        logic found;

        // ---- reset state ----
        #12;
        check("rst_valid_out", valid_out, 0);
        check("rst_sop_out", sop_out, 0);
        check("rst_eop_out", eop_out, 0);
        check("rst_inv_out", inv_out, 0);
        check("rst_err_sop", err_sop, 0);
        check("rst_y_re", y_re, 0);
        check("rst_y_im", y_im, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("rst_in_ready", in_ready, 1);

        // ---- bit-reversed single frame and latency ----
        q.delete();
        refused = 0;
        send_frame(1'b0, 0, 16'h100, refused);
        stop_in();
        check("t1_refused", refused, 0);
        check("t1_valid_at_last_edge", valid_out, 0);
        @(posedge clk);
        #1;
        check("t1_valid_next_edge", valid_out, 1);
        check("t1_sop_next_edge", sop_out, 1);
        check("t1_y_re_first", y_re, 0);
        wait_q("t1_count", N, 20);
        for (int j = 0; j < N; j++) begin
            check($sformatf("t1_re%0d", j), q[j].re, br3(j));
            check($sformatf("t1_im%0d", j), q[j].im, 16'h100 + br3(j));
            check($sformatf("t1_sop%0d", j), q[j].sop, (j == 0) ? 1 : 0);
            check($sformatf("t1_eop%0d", j), q[j].eop, (j == N-1) ? 1 : 0);
        end

        // ---- four back-to-back frames ----
        q.delete();
        refused = 0;
        for (int f = 0; f < 4; f++) send_frame(1'b0, f*16, 16'h200 + f*16, refused);
        stop_in();
        check("t2_in_ready_never_low", refused, 0);
        wait_q("t2_count", 4*N, 60);
        gaps = 0;
        sops = 0;
        for (int j = 1; j < q.size(); j++) if (q[j].cyc != q[j-1].cyc + 1) gaps++;
        for (int j = 0; j < q.size(); j++) if (q[j].sop) sops++;
        check("t2_contiguous", gaps, 0);
        check("t2_sop_count", sops, 4);
        for (int j = 0; j < 4*N; j++)
            check($sformatf("t2_re%0d", j), q[j].re, (j / N) * 16 + br3(j % N));
        repeat (5) @(posedge clk);
        #1 check("t2_no_extra", q.size(), 4*N);

        // ---- backpressure ----
        q.delete();
        refused   = 0;
        out_ready = 1'b0;
        send_frame(1'b0, 16'h20, 16'h300, refused);
        send_frame(1'b0, 16'h30, 16'h380, refused);
        stop_in();
        check("t3_refused", refused, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_in_ready_low", in_ready, 0);
        check("t3_hold_valid", valid_out, 1);
        check("t3_hold_sop", sop_out, 1);
        beat(1'b1, 1'b0, 16'h99, 16'h0, acc);
        stop_in();
        check("t3_extra_refused", acc, 0);
        check("t3_hold_y_re", y_re, 16'h20);
        check("t3_hold_y_im", y_im, 16'h300);
        out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (valid_out && eop_out) found = 1'b1;
        end
        check("t3_eop_seen", found, 1);
        @(posedge clk);
        #1 check("t3_in_ready_back", in_ready, 1);
        wait_q("t3_count", 2*N, 40);
        for (int j = 0; j < 2*N; j++)
            check($sformatf("t3_re%0d", j), q[j].re,
                  ((j < N) ? 16'h20 : 16'h30) + br3(j % N));

        // ---- early sop restarts the frame ----
        q.delete();
        err_pulses = 0;
        for (int i = 0; i < 5; i++) beat(i == 0, 1'b0, DW'(16'h40 + i), DW'(16'h400 + i), acc);
        refused = 0;
        send_frame(1'b0, 16'h50, 16'h500, refused);
        stop_in();
        wait_q("t4_count", N, 30);
        repeat (10) @(posedge clk);
        #1;
        check("t4_no_extra", q.size(), N);
        check("t4_err_pulses", err_pulses, 1);
        for (int j = 0; j < N; j++) begin
            check($sformatf("t4_re%0d", j), q[j].re, 16'h50 + br3(j));
            check($sformatf("t4_im%0d", j), q[j].im, 16'h500 + br3(j));
        end

        // ---- inverse frame then a normal frame ----
        q.delete();
        for (int i = 0; i < N; i++) beat(i == 0, i == 0, DW'(16'h60 + i), im_in[i], acc);
        for (int i = 0; i < N; i++) beat(i == 0, 1'b0, DW'(16'h70 + i), im_in[i], acc);
        stop_in();
        wait_q("t5_count", 2*N, 40);
        for (int j = 0; j < 2*N; j++) begin
            idx = br3(j % N);
            if (j < N) begin
                check($sformatf("t5_inv_im%0d", j), q[j].im, im_conj[idx]);
                check($sformatf("t5_inv_flag%0d", j), q[j].inv, 1);
                check($sformatf("t5_inv_re%0d", j), q[j].re, 16'h60 + idx);
            end else begin
                check($sformatf("t5_fwd_im%0d", j), q[j].im, im_in[idx]);
                check($sformatf("t5_fwd_flag%0d", j), q[j].inv, 0);
            end
        end

        // ---- reset in the middle of streaming ----
        q.delete();
        refused = 0;
        send_frame(1'b0, 16'h80, 16'h800, refused);
        for (int i = 0; i < 3; i++) beat(i == 0, 1'b0, DW'(16'h90 + i), DW'(16'h900 + i), acc);
        check("t6_streaming", valid_out, 1);
        #2;
        rst = 1'b1;
        stop_in();
        #1;
        check("t6_valid_out", valid_out, 0);
        check("t6_sop_out", sop_out, 0);
        check("t6_eop_out", eop_out, 0);
        check("t6_inv_out", inv_out, 0);
        check("t6_y_re", y_re, 0);
        check("t6_y_im", y_im, 0);
        check("t6_err_sop", err_sop, 0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("t6_in_ready", in_ready, 1);
        repeat (20) @(posedge clk);
        #1 check("t6_no_stale", q.size(), 0);
        send_frame(1'b0, 16'hA0, 16'hA00, refused);
        stop_in();
        wait_q("t6_count", N, 20);
        for (int j = 0; j < N; j++)
            check($sformatf("t6_re%0d", j), q[j].re, 16'hA0 + br3(j));
        check("t6_new_sop", q[0].sop, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_buf.md
Name: fft_frame_buf

Overview:
- Parametrised ping-pong input frame buffer that sits in front of the FFT core.
- Collects N = 2^LOG2N complex samples per frame, delimited by sop_in.
- Streams each completed frame out in bit-reversed or natural order, with per-frame inverse/conjugate mode and valid/ready backpressure.
- Successor of the fixed 256-point input buffer: point count, data width and read order are configurable, and it adds flow control and frame-error handling.

Parameters:
- LOG2N, 8, log2 of frame length N (legal 3..12).
- DW, 16, sample width per real/imag component, signed two's complement.
- BITREV, 1, 1 = read addresses bit-reversed (DIT input order); 0 = natural order.
- CONJ_INV, 1, 1 = negate the imaginary part on output for frames tagged inv (IFFT via conjugation); 0 = pass inv through only.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inv_in  in  1  inverse flag, sampled with the sop_in beat.
- valid_in  in  1  input sample valid.
- sop_in  in  1  first sample of frame.
- in_ready  out  1  buffer can accept a sample this cycle.
- x_re  in  DW  input real.
- x_im  in  DW  input imag.
- valid_out  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- sop_out  out  1  first output sample of frame.
- eop_out  out  1  last output sample of frame.
- inv_out  out  1  inverse flag of the frame being output.
- y_re  out  DW  output real.
- y_im  out  DW  output imag.
- err_sop  out  1  one-cycle pulse: frame restarted by early sop_in.

Behaviour:
- Reset (async, rst=1): both banks empty, write and read counters 0, write bank 0.
  - Outputs: valid_out, sop_out, eop_out, inv_out, err_sop, y_re and y_im = 0.
  - in_ready = 1 once rst deasserts.
  - Reset mid-frame discards all buffered data.
- Storage: two banks of N x 2*DW; asynchronous read, synchronous write.
- Write FSM states:
  - IDLE. A beat accepted here (valid_in & in_ready) without sop_in is dropped silently.
  - FILL. A sop beat writes index 0, latches inv_in for the bank and enters FILL. Each accepted beat writes at index wr_cnt, natural order.
  - On the beat writing index N-1: mark bank full, toggle write bank, return to IDLE.
- sop_in inside FILL (at wr_cnt != 0):
  - Pulse err_sop for one cycle.
  - Restart the current bank: the sop sample goes to index 0, wr_cnt = 1, inv is relatched.
- in_ready = 0 only while the current write bank is full, i.e. both banks full.
- Read FSM states IDLE / STREAM:
  - Leave IDLE when the read bank is full.
  - Read address = bitrev(rd_cnt) if BITREV, else rd_cnt.
  - Output register loads when (!valid_out | out_ready).
  - Holding: y_re, y_im, sop_out, eop_out and inv_out stay stable while valid_out & !out_ready.
  - sop_out is set with rd_cnt = 0; eop_out with rd_cnt = N-1.
  - After the N-1 load: clear bank full, toggle read bank, return to IDLE or stay in STREAM if the other bank is already full (no bubble).
- Latency and throughput:
  - Last input beat at edge k gives the first valid_out from edge k+1.
  - Throughput is 1 sample/cycle with out_ready = 1.
- Simultaneous events: a write completing bank A in the same cycle the read releases bank B is legal. Both take effect, and in_ready stays 1 the next cycle.
- Conjugation: when CONJ_INV = 1 and the frame's inv = 1, y_im = -x_im.
  - -(-2^(DW-1)) saturates to 2^(DW-1)-1.
  - y_re is never modified.

Decomposition:
- Package fft_pkg holds:
  - localparam functions clog2 and bitrev(value, LOG2N);
  - sat_neg(DW) helper;
  - write-FSM and read-FSM state enums.
- One natural sub-module: fft_bank_ram, a parameterised N x 2*DW RAM with a single write port and an asynchronous read port, instantiated twice.

Test Plan:
- Bit-reversed order: LOG2N = 3, BITREV = 1, frame re = 0..7, out_ready = 1 -> y_re 0,4,2,6,1,5,3,7; sop_out on 0, eop_out on 7; valid_out one cycle after the last input.
- Back-to-back frames: four N = 256 frames, continuous valid_in -> 1024 contiguous valid_out, in_ready never low, each frame's data intact.
- Backpressure: out_ready = 0 -> in_ready falls after 2N accepted beats. Then out_ready = 1 -> frame 0 drains first, and in_ready returns the cycle after frame 0's eop is accepted.
- Early sop: sop at beat 0, 5 samples, sop again at beat 5 -> err_sop pulses once; the output frame starts with the second sop sample.
- Inverse: inv_in = 1, x_im = -32768, 1000, 0 -> y_im = 32767, -1000, 0; inv_out = 1 for the whole frame; the next inv_in = 0 frame is unmodified.
- Reset mid-stream: rst pulsed during sample 100 of output -> all outputs 0 immediately, no stale frame afterwards, and a new sop frame outputs correctly.
